// File: rtl/pipeline_types.sv
// Shared front-end types: fetch FSM states, exception codes and slot indices.
package pipeline_types;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_EXC,
      S_HALT
   } fetch_state_t;

   localparam logic [6:0] ECODE_ADEF = 7'h08;
   localparam int unsigned EXC_IF = 0;

   function automatic logic [31:0] seq_pc(input logic [31:0] pc);
      return {pc[31:3] + 29'd1, 3'b000};
   endfunction

endpackage

// File: rtl/fetch_pc_gen.sv
// Front-end PC generator / icache request sequencer, two-slot 8-byte groups.
// FETCH_PC_GEN_ADEF_EN enables misaligned-PC (ADEF) exception and halt.
module fetch_pc_gen
   import pipeline_types::*;
#(
   parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic [31:0]           new_pc,
   input  logic                  stall,
   input  logic                  buffer_full,
   input  logic                  pre_taken,
   input  logic [31:0]           pre_branch_addr,
   output logic                  icache_req,
   output logic [31:0]           icache_addr,
   input  logic                  icache_ready,
   input  logic                  icache_rvalid,
   output logic                  icache_rready,
   output logic [31:0]           fetch_pc_o,
   output logic [1:0][31:0]      pc_o,
   output logic [1:0]            fetch_en_o,
   output logic [1:0][5:0]       is_exception_o,
   output logic [1:0][5:0][6:0]  exception_cause_o
);

   fetch_state_t state;
   logic [31:0]  pc_q;
   logic [31:0]  pc_next;
   logic         discard_q;
   logic         in_req;
   logic         misal;
   logic         accept;
   logic         consume;
   logic         drop;

`ifdef FETCH_PC_GEN_ADEF_EN
   logic exc_fire;
   assign misal    = pc_q[1:0] != 2'b00;
   assign exc_fire = (state == S_EXC) && !stall && !flush;
`else
   assign misal = 1'b0;
`endif

   assign in_req        = state == S_REQ;
   assign icache_req    = in_req && !misal && !buffer_full && !stall;
   assign icache_addr   = in_req ? {pc_q[31:2], 2'b00} : '0;
   assign accept        = icache_req && icache_ready;
   assign icache_rready = (state == S_WAIT) && !stall;
   assign consume       = icache_rvalid && icache_rready;
   assign drop          = discard_q || flush;
   assign fetch_pc_o    = pc_q;

   always_comb begin : next_pc_mux
      if (flush)
         pc_next = new_pc;
      else if (pre_taken)
         pc_next = pre_branch_addr;
      else
         pc_next = seq_pc(pc_q);
   end

   always_comb begin
      fetch_en_o        = '0;
      pc_o              = '0;
      is_exception_o    = '0;
      exception_cause_o = '0;
      if (consume) begin
         pc_o[0] = pc_q;
         pc_o[1] = {pc_q[31:3], 3'b100};
         if (!drop)
            fetch_en_o = {!pc_q[2], 1'b1};
      end
`ifdef FETCH_PC_GEN_ADEF_EN
      if (exc_fire) begin
         fetch_en_o                   = 2'b01;
         pc_o[0]                      = pc_q;
         is_exception_o[0][EXC_IF]    = 1'b1;
         exception_cause_o[0][EXC_IF] = ECODE_ADEF;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= S_IDLE;
         pc_q      <= RESET_PC;
         discard_q <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: state <= S_REQ;
            S_REQ: begin
               if (flush)
                  pc_q <= new_pc;
               if (accept) begin
                  state     <= S_WAIT;
                  discard_q <= flush;
               end else if (misal && !flush) begin
                  state <= S_EXC;
               end
            end
            S_WAIT: begin
               // a discarded response must not advance the redirected PC
               if (consume) begin
                  state     <= S_REQ;
                  discard_q <= 1'b0;
                  if (flush || !discard_q)
                     pc_q <= pc_next;
               end else if (flush) begin
                  pc_q      <= new_pc;
                  discard_q <= 1'b1;
               end
            end
`ifdef FETCH_PC_GEN_ADEF_EN
            S_EXC: begin
               if (flush) begin
                  pc_q  <= new_pc;
                  state <= S_REQ;
               end else if (!stall) begin
                  state <= S_HALT;
               end
            end
            S_HALT: begin
               if (flush) begin
                  pc_q  <= new_pc;
                  state <= S_REQ;
               end
            end
`endif
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Scoreboard bench for fetch_pc_gen with a small icache response model.
// Define FETCH_PC_GEN_ADEF_EN to also cover the misaligned-PC path.
module tb_fetch_pc_gen;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 flush;
   logic [31:0]          new_pc;
   logic                 stall;
   logic                 buffer_full;
   logic                 pre_taken;
   logic [31:0]          pre_branch_addr;
   logic                 icache_req;
   logic [31:0]          icache_addr;
   logic                 icache_ready;
   logic                 icache_rvalid;
   logic                 icache_rready;
   logic [31:0]          fetch_pc_o;
   logic [1:0][31:0]     pc_o;
   logic [1:0]           fetch_en_o;
   logic [1:0][5:0]      is_exception_o;
   logic [1:0][5:0][6:0] exception_cause_o;

   typedef struct {
      logic [1:0]  en;
      logic [31:0] pc0;
      logic [31:0] pc1;
      logic        exc;
      logic [6:0]  cause;
   } exp_t;

   logic [31:0] exp_addr[$];
   exp_t        exp_push[$];

   int checks = 0;
   int errors = 0;
   int acc_cnt = 0;
   int lat = 0;
   int cnt = 0;
   bit outstanding = 0;

   localparam logic [31:0] RST_PC = 32'h1c00_0000;

   fetch_pc_gen dut (
      .clk(clk),
      .rst(rst),
      .flush(flush),
      .new_pc(new_pc),
      .stall(stall),
      .buffer_full(buffer_full),
      .pre_taken(pre_taken),
      .pre_branch_addr(pre_branch_addr),
      .icache_req(icache_req),
      .icache_addr(icache_addr),
      .icache_ready(icache_ready),
      .icache_rvalid(icache_rvalid),
      .icache_rready(icache_rready),
      .fetch_pc_o(fetch_pc_o),
      .pc_o(pc_o),
      .fetch_en_o(fetch_en_o),
      .is_exception_o(is_exception_o),
      .exception_cause_o(exception_cause_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   // one cycle: monitor just after negedge, model updates on posedge
   task automatic step();
      logic  acc;
      logic  con;
      exp_t  e;
      logic [31:0] ea;
      acc = 1'b0;
      #1;
      if (rst) begin
         if (icache_req && icache_ready) begin
            acc = 1'b1;
            if (exp_addr.size() == 0) begin
               check("addr_unexp", 64'(exp_addr.size()), 1);
            end else begin
               ea = exp_addr.pop_front();
               check("addr", icache_addr, ea);
            end
         end
         if ((icache_rvalid && icache_rready) || fetch_en_o != 2'b00) begin
            if (exp_push.size() == 0) begin
               check("push_unexp", 64'(exp_push.size()), 1);
            end else begin
               e = exp_push.pop_front();
               check("en", fetch_en_o, e.en);
               if (e.en[0]) check("pc0", pc_o[0], e.pc0);
               if (e.en[1]) check("pc1", pc_o[1], e.pc1);
               check("exc", is_exception_o[0][0], e.exc);
               check("cause", exception_cause_o[0][0], e.cause);
            end
         end
      end
      con = icache_rvalid && icache_rready;
      @(posedge clk);
      if (!rst) begin
         outstanding = 0;
      end else begin
         if (con) outstanding = 0;
         if (acc) begin
            outstanding = 1;
            cnt = lat;
            acc_cnt++;
         end
      end
      @(negedge clk);
      if (outstanding) begin
         if (cnt == 0) icache_rvalid = 1'b1;
         else cnt--;
      end else begin
         icache_rvalid = 1'b0;
      end
   endtask

   task automatic group_acc(input logic [31:0] a, input logic [1:0] en,
                            input bit resp);
      exp_t e;
      int n;
      int k;
      e.en = en;
      e.pc0 = a;
      e.pc1 = {a[31:3], 3'b100};
      e.exc = 1'b0;
      e.cause = 7'h00;
      exp_addr.push_back(a);
      if (resp) exp_push.push_back(e);
      buffer_full = 1'b0;
      n = acc_cnt;
      k = 0;
      while (acc_cnt == n && k < 50) begin
         step();
         k++;
      end
      check("acc_timeout", 64'(acc_cnt - n), 1);
      buffer_full = 1'b1;
   endtask

   task automatic wait_rsp();
      int k;
      k = 0;
      while (!icache_rvalid && k < 50) begin
         step();
         k++;
      end
      check("rsp_timeout", icache_rvalid, 1);
   endtask

   initial begin
      rst = 1'b0;
      flush = 1'b0;
      new_pc = '0;
      stall = 1'b0;
      buffer_full = 1'b1;
      pre_taken = 1'b0;
      pre_branch_addr = '0;
      icache_ready = 1'b1;
      icache_rvalid = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check("rst_req", icache_req, 0);
      check("rst_addr", icache_addr, 0);
      check("rst_rready", icache_rready, 0);
      check("rst_en", fetch_en_o, 0);
      check("rst_pc", pc_o, 0);
      check("rst_exc", is_exception_o, 0);
      check("rst_fpc", fetch_pc_o, RST_PC);

      // release: IDLE one cycle, then first request
      rst = 1'b1;
      buffer_full = 1'b0;
      check("idle_req", icache_req, 0);
      step();
      #1;
      check("first_req", icache_req, 1);
      for (int i = 0; i < 3; i++) begin
         group_acc(RST_PC + 32'(8 * i), 2'b11, 1);
         wait_rsp();
         step();
      end

      // flush while waiting: response discarded, fetch redirected
      lat = 2;
      group_acc(32'h1c00_0018, 2'b00, 1);
      flush = 1'b1;
      new_pc = 32'h1c00_0104;
      step();
      flush = 1'b0;
      wait_rsp();
      step();
      lat = 0;
      group_acc(32'h1c00_0104, 2'b01, 1);
      wait_rsp();
      step();

      // flush in REQ without accept
      flush = 1'b1;
      new_pc = RST_PC;
      step();
      flush = 1'b0;
      #1;
      check("flush_addr", icache_addr, RST_PC);

      // predicted taken, then flush beats pre_taken on the same cycle
      group_acc(RST_PC, 2'b11, 1);
      wait_rsp();
      pre_taken = 1'b1;
      pre_branch_addr = 32'h1c00_0200;
      step();
      pre_taken = 1'b0;
      group_acc(32'h1c00_0200, 2'b00, 1);
      wait_rsp();
      flush = 1'b1;
      new_pc = 32'h1c00_0300;
      pre_taken = 1'b1;
      pre_branch_addr = 32'h1c00_0400;
      step();
      flush = 1'b0;
      pre_taken = 1'b0;
      group_acc(32'h1c00_0300, 2'b11, 1);
      wait_rsp();
      step();

      // stall holds the response, buffer_full blocks requests
      group_acc(32'h1c00_0308, 2'b11, 1);
      wait_rsp();
      stall = 1'b1;
      repeat (3) begin
         #1;
         check("stall_rready", icache_rready, 0);
         check("stall_en", fetch_en_o, 0);
         step();
      end
      stall = 1'b0;
      step();
      repeat (3) begin
         #1;
         check("full_req", icache_req, 0);
         step();
      end

      // reset while a response is pending
      group_acc(32'h1c00_0310, 2'b11, 0);
      wait_rsp();
      rst = 1'b0;
      step();
      #1;
      check("mrst_en", fetch_en_o, 0);
      check("mrst_req", icache_req, 0);
      check("mrst_pc", pc_o, 0);
      check("mrst_fpc", fetch_pc_o, RST_PC);
      rst = 1'b1;
      step();
      group_acc(RST_PC, 2'b11, 1);
      wait_rsp();
      step();

`ifdef FETCH_PC_GEN_ADEF_EN
      begin
         exp_t ex;
         flush = 1'b1;
         new_pc = 32'h1c00_0002;
         step();
         flush = 1'b0;
         buffer_full = 1'b0;
         #1;
         check("adef_req", icache_req, 0);
         ex.en = 2'b01;
         ex.pc0 = 32'h1c00_0002;
         ex.pc1 = '0;
         ex.exc = 1'b1;
         ex.cause = 7'h08;
         exp_push.push_back(ex);
         step();
         step();
         repeat (3) begin
            #1;
            check("halt_req", icache_req, 0);
            step();
         end
         flush = 1'b1;
         new_pc = RST_PC;
         step();
         flush = 1'b0;
         group_acc(RST_PC, 2'b11, 1);
         wait_rsp();
         step();
      end
`endif

      repeat (2) step();
      check("sb_addr_left", 64'(exp_addr.size()), 0);
      check("sb_push_left", 64'(exp_push.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_pc_gen.md
# fetch_pc_gen

Front-end PC generator and icache request sequencer sitting directly upstream of the instruction buffer. Produces 8-byte-aligned two-slot fetch groups, drives the icache request/response handshake, and applies redirects from the backend (flush) and from the BPU (predicted-taken). Per-slot PCs, fetch enables and IF-stage exception info go to the instruction buffer together with the icache response.

## Interface
- RESET_PC, 32'h1c00_0000, first fetch address after reset
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- flush  in  1  backend redirect, highest priority
- new_pc  in  32  redirect target, valid with flush
- stall  in  1  front-end stall; blocks response consumption
- buffer_full  in  1  instruction buffer full; blocks new requests
- pre_taken  in  1  BPU predicts taken for the group being returned
- pre_branch_addr  in  32  BPU target, valid with pre_taken
- icache_req  out  1  request valid
- icache_addr  out  32  request address (group PC)
- icache_ready  in  1  icache accepts request this cycle
- icache_rvalid  in  1  response valid; held by icache until consumed
- icache_rready  out  1  response consumed (= !stall)
- fetch_pc_o  out  32  PC of group being requested (to BPU)
- pc_o  out  [1:0][31:0]  slot PCs of consumed group
- fetch_en_o  out  [1:0]  per-slot push enable to instruction buffer
- is_exception_o  out  [1:0][5:0]  per-slot exception flags; bit 0 = IF stage
- exception_cause_o  out  [1:0][5:0][6:0]  per-slot causes; entry 0 = IF stage

## Operation
- Group PC pc_q; slot0 = pc_q, slot1 = {pc_q[31:3], 3'b100}. pc_q[2]=1 → slot1 disabled.
- Sequential next = {pc_q[31:3] + 1, 3'b000}; wraps at 32 bits, no flag.
- States: S_IDLE, S_REQ, S_WAIT, S_EXC, S_HALT.
- S_IDLE: entered on reset; next cycle → S_REQ.
- S_REQ: icache_req = !buffer_full && !stall; icache_addr = pc_q. Handshake completes on icache_req && icache_ready → S_WAIT. icache_addr may change while icache_req=1 without icache_ready.
- S_WAIT: consume on icache_rvalid && icache_rready. fetch_en_o = {slot1_ok, 1} unless discard_q. pc_q updates: flush → new_pc, else pre_taken → pre_branch_addr, else sequential. Go to S_REQ the same cycle (back-to-back: one group per 2 cycles minimum).
- Flush in S_REQ with no accept: pc_q ← new_pc, stay. Flush in S_WAIT (or coinciding with accept): pc_q ← new_pc, set discard_q; the pending response is consumed with fetch_en_o = 0; discard_q clears on consumption. Flush coinciding with consumption: that response is discarded.
- pre_taken ignored when response is discarded.
- stall while rvalid: response held, nothing emitted; consumed first non-stall cycle.
- fetch_en_o, pc_o, exception outputs are combinational, valid only in the consumption cycle; zero otherwise.

## Timing
- Reset (rst=0 at edge): state S_IDLE, pc_q = RESET_PC, discard_q = 0; all outputs 0 except fetch_pc_o = RESET_PC.
- Reset mid-transaction: outstanding response discarded by icache reset; block restarts at RESET_PC.
- First icache_req: 2nd cycle after rst deasserts.
- Request-accept to earliest push: 1 cycle (rvalid cycle after accept).
- flush takes effect on icache_addr the following cycle.

## Configuration
- FETCH_PC_GEN_ADEF_EN defined: in S_REQ, pc_q[1:0] != 0 suppresses icache_req and enters S_EXC; S_EXC emits one cycle fetch_en_o = 2'b01, pc_o[0] = pc_q, is_exception_o[0][0] = 1, exception_cause_o[0][0] = ECODE_ADEF (skipped while stall); then S_HALT until flush (flush → S_REQ at new_pc).
- Undefined: pc_q[1:0] ignored, forced to 0 on icache_addr; S_EXC/S_HALT unreachable; exception outputs constant 0.

## Structure
- Shared package pipeline_types: fetch_state_t enum, ECODE_ADEF (7'h08), IF-stage exception index constant.
- Single module; no sub-module. Next-PC mux as a local always_comb.

## Test plan
- Reset release, icache_ready=1, rvalid one cycle after accept -> addrs 1c000000, 1c000008, 1c000010; each push fetch_en_o=2'b11.
- flush new_pc=1c000104 during S_WAIT -> pending response pushed with fetch_en_o=0; next icache_addr=1c000104; push fetch_en_o=2'b01, pc_o[0]=1c000104.
- pre_taken=1, pre_branch_addr=1c000200 on consumption of group 1c000000 -> next icache_addr=1c000200; flush same cycle to 1c000300 wins.
- stall=1 for 3 cycles while rvalid=1 -> icache_rready=0, fetch_en_o=0 during stall; single push after release; buffer_full=1 -> no icache_req.
- ADEF build, flush new_pc=1c000002 -> no icache_req; one push fetch_en_o=01, is_exception_o[0][0]=1, cause 7'h08; halts until next flush.
- rst=0 asserted while S_WAIT -> outputs zero next cycle; restart fetch at RESET_PC.
